// File: rtl/aud_pkg.sv
// Shared constants and helpers for the WM8978 I2S audio paths.
// Used by both the DAC transmitter and the ADC receiver.
package aud_pkg;

   typedef logic [5:0] aud_cnt_t;

   localparam aud_cnt_t AUD_CNT_IDLE = 6'd35;
   localparam aud_cnt_t AUD_CNT_DONE = 6'd32;
   localparam aud_cnt_t AUD_WL_DEF   = 6'd16;

   // Keeps only the low wl bits of a sample word.
   function automatic logic [31:0] wl_mask(input aud_cnt_t wl);
      if (wl >= 6'd32) begin
         return '1;
      end
      return (32'd1 << wl) - 32'd1;
   endfunction

endpackage

// File: rtl/aud_lrc_edge.sv
// LRC change detector: one register of aud_lrc plus an XOR.
// Shared by the I2S transmit and receive paths.
module aud_lrc_edge (
   input  logic aud_bclk,
   input  logic rst_n,
   input  logic aud_lrc,
   output logic lrc_edge
);

   logic lrc_d0;

   always_ff @(posedge aud_bclk or negedge rst_n) begin
      if (!rst_n) begin
         lrc_d0 <= 1'b0;
      end else begin
         lrc_d0 <= aud_lrc;
      end
   end

   assign lrc_edge = aud_lrc ^ lrc_d0;

endmodule

// File: rtl/aud_i2s_tx.sv
// I2S transmitter to the WM8978 DAC (codec is clock master).
// One word per LRC slot, MSB first, one BCLK after each LRC change.
module aud_i2s_tx
   import aud_pkg::*;
#(
   parameter aud_cnt_t WL = AUD_WL_DEF
) (
   input  logic        aud_bclk,
   input  logic        rst_n,
   input  logic        aud_lrc,
   output logic        aud_dacdat,
   input  logic [31:0] dac_data,
   input  logic        dac_valid,
   output logic        dac_ready,
   output logic        tx_chan,
   output logic        tx_done,
   output logic        underrun
);

   logic        lrc_edge;
   logic        hold_full;
   logic [31:0] hold;
   logic [31:0] shreg;
   aud_cnt_t    tx_cnt;
   logic [4:0]  bit_idx;

   aud_lrc_edge u_edge (
      .aud_bclk (aud_bclk),
      .rst_n    (rst_n),
      .aud_lrc  (aud_lrc),
      .lrc_edge (lrc_edge)
   );

   assign dac_ready = ~hold_full;

   // A word taken on the slot-start edge only fills hold; there is
   // deliberately no bypass into shreg, so it plays one slot later.
   always_ff @(posedge aud_bclk or negedge rst_n) begin
      if (!rst_n) begin
         hold_full <= 1'b0;
         hold      <= '0;
         shreg     <= '0;
         tx_cnt    <= AUD_CNT_IDLE;
         tx_chan   <= 1'b0;
         tx_done   <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         underrun <= 1'b0;
         tx_done  <= (tx_cnt == AUD_CNT_DONE);
         if (dac_valid && !hold_full) begin
            hold      <= dac_data;
            hold_full <= 1'b1;
         end
         if (lrc_edge) begin
            tx_cnt  <= '0;
            tx_chan <= aud_lrc;
            if (hold_full) begin
               shreg     <= hold & wl_mask(WL);
               hold_full <= 1'b0;
            end else begin
               shreg    <= '0;
               underrun <= 1'b1;
            end
         end else if (tx_cnt < AUD_CNT_IDLE) begin
            tx_cnt <= tx_cnt + 6'd1;
         end
      end
   end

   assign bit_idx = 5'(WL - 6'd1 - tx_cnt);

   always_ff @(negedge aud_bclk or negedge rst_n) begin
      if (!rst_n) begin
         aud_dacdat <= 1'b0;
      end else begin
         aud_dacdat <= (tx_cnt < WL) ? shreg[bit_idx] : 1'b0;
      end
   end

endmodule

// File: tb/tb_aud_i2s_tx.sv
// Directed bench for aud_i2s_tx: WL=16 main instance plus a WL=24 copy.
// LRC is driven between edges; outputs are sampled 1 time unit after posedge.
module tb_aud_i2s_tx;

   logic        aud_bclk;
   logic        rst_n;
   logic        aud_lrc;
   logic        aud_dacdat;
   logic [31:0] dac_data;
   logic        dac_valid;
   logic        dac_ready;
   logic        tx_chan;
   logic        tx_done;
   logic        underrun;

   logic        d24_dat;
   logic [31:0] d24_data;
   logic        d24_valid;
   logic        d24_ready;
   logic        d24_chan;
   logic        d24_done;
   logic        d24_und;

   int checks;
   int errors;

   logic [31:0] feed_q [8];
   int          feed_n;
   int          feed_idx;

   logic [63:0] cap;
   logic [63:0] cap24;
   int          acc_cnt;
   int          ready_cnt;
   int          done_cnt;
   int          done_at;
   logic        und1;
   logic        und24_1;
   logic        chan1;

   aud_i2s_tx #(.WL(6'd16)) dut (
      .aud_bclk   (aud_bclk),
      .rst_n      (rst_n),
      .aud_lrc    (aud_lrc),
      .aud_dacdat (aud_dacdat),
      .dac_data   (dac_data),
      .dac_valid  (dac_valid),
      .dac_ready  (dac_ready),
      .tx_chan    (tx_chan),
      .tx_done    (tx_done),
      .underrun   (underrun)
   );

   aud_i2s_tx #(.WL(6'd24)) dut24 (
      .aud_bclk   (aud_bclk),
      .rst_n      (rst_n),
      .aud_lrc    (aud_lrc),
      .aud_dacdat (d24_dat),
      .dac_data   (d24_data),
      .dac_valid  (d24_valid),
      .dac_ready  (d24_ready),
      .tx_chan    (d24_chan),
      .tx_done    (d24_done),
      .underrun   (d24_und)
   );

   initial aud_bclk = 1'b0;
   always #5 aud_bclk = ~aud_bclk;

   function automatic logic [31:0] rx_word(input logic [63:0] c, input int wl);
      logic [31:0] r;
      r = '0;
      for (int k = 2; k <= wl + 1; k++) begin
         r = {r[30:0], c[k]};
      end
      return r;
   endfunction

   function automatic logic tail_or(input logic [63:0] c, input int a, input int b);
      logic r;
      r = 1'b0;
      for (int k = a; k <= b; k++) begin
         r = r | c[k];
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge aud_bclk);
      #1;
   endtask

   task automatic feed_start(input int n);
      feed_n    = n;
      feed_idx  = 0;
      dac_data  = feed_q[0];
      dac_valid = 1'b1;
   endtask

   task automatic feed_tick();
      logic r;
      r = dac_valid & dac_ready;
      tick();
      if (r) begin
         acc_cnt++;
         feed_idx++;
         if (feed_idx < feed_n) begin
            dac_data = feed_q[feed_idx];
         end else begin
            dac_valid = 1'b0;
         end
      end
   endtask

   task automatic push_idle(input logic [31:0] w);
      feed_q[0] = w;
      feed_start(1);
      for (int i = 0; i < 100 && dac_valid; i++) begin
         feed_tick();
      end
      checks++;
      if (dac_valid !== 1'b0) begin
         errors++;
         $display("FAIL push_timeout valid=%b want 0", dac_valid);
         dac_valid = 1'b0;
      end
   endtask

   task automatic play_slot(input logic lrc, input int len);
      aud_lrc   = lrc;
      cap       = '0;
      cap24     = '0;
      acc_cnt   = 0;
      ready_cnt = 0;
      done_cnt  = 0;
      done_at   = 0;
      for (int k = 1; k <= len; k++) begin
         feed_tick();
         cap[k]   = aud_dacdat;
         cap24[k] = d24_dat;
         if (dac_ready) ready_cnt++;
         if (tx_done) begin
            done_cnt++;
            done_at = k;
         end
         if (k == 1) begin
            und1    = underrun;
            und24_1 = d24_und;
            chan1   = tx_chan;
         end
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      aud_lrc   = 1'b0;
      dac_valid = 1'b0;
      dac_data  = '0;
      d24_valid = 1'b0;
      d24_data  = '0;
      feed_n    = 0;
      feed_idx  = 0;
      repeat (3) tick();
      checks++;
      if (aud_dacdat !== 1'b0) begin
         errors++;
         $display("FAIL rst_dacdat got %b want 0", aud_dacdat);
      end
      checks++;
      if (dac_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_ready got %b want 1", dac_ready);
      end
      checks++;
      if ({tx_chan, tx_done, underrun} !== 3'b000) begin
         errors++;
         $display("FAIL rst_flags got %b want 000", {tx_chan, tx_done, underrun});
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_pre_edge();
      int bad;
      push_idle(32'h0000_8421);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (aud_dacdat !== 1'b0 || underrun !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL pre_edge_idle got %0d active cycles want 0", bad);
      end
      checks++;
      if (dac_ready !== 1'b0) begin
         errors++;
         $display("FAIL pre_edge_hold ready=%b want 0", dac_ready);
      end
      play_slot(1'b1, 40);
      checks++;
      if (rx_word(cap, 16) !== 32'h8421 || und1 !== 1'b0 || chan1 !== 1'b1) begin
         errors++;
         $display("FAIL pre_edge_word got %h und=%b chan=%b want 8421 0 1",
                  rx_word(cap, 16), und1, chan1);
      end
   endtask

   task automatic test_basic();
      push_idle(32'h0000_A5C3);
      play_slot(1'b0, 40);
      checks++;
      if (rx_word(cap, 16) !== 32'h0000_A5C3) begin
         errors++;
         $display("FAIL basic_word got %h want 0000a5c3", rx_word(cap, 16));
      end
      checks++;
      if (tail_or(cap, 18, 40) !== 1'b0) begin
         errors++;
         $display("FAIL basic_tail got %b want 0", tail_or(cap, 18, 40));
      end
      checks++;
      if (done_cnt !== 1 || done_at !== 34) begin
         errors++;
         $display("FAIL basic_done got cnt=%0d at=%0d want 1 34", done_cnt, done_at);
      end
      checks++;
      if (chan1 !== 1'b0 || und1 !== 1'b0) begin
         errors++;
         $display("FAIL basic_flags got chan=%b und=%b want 0 0", chan1, und1);
      end
   endtask

   task automatic test_loopback();
      logic        l;
      logic [31:0] w;
      for (int i = 0; i < 8; i++) begin
         l = (i % 2 == 0);
         w = l ? 32'h0000_FEDC : 32'h0000_1234;
         push_idle(w);
         play_slot(l, 40);
         checks++;
         if (rx_word(cap, 16) !== w || chan1 !== l) begin
            errors++;
            $display("FAIL loop_%0d got %h chan=%b want %h %b",
                     i, rx_word(cap, 16), chan1, w, l);
         end
      end
   endtask

   task automatic test_underrun();
      feed_q[0] = 32'h0000_9A6B;
      feed_start(1);
      play_slot(1'b1, 40);
      checks++;
      if (und1 !== 1'b1 || acc_cnt !== 1) begin
         errors++;
         $display("FAIL und_pulse got und=%b acc=%0d want 1 1", und1, acc_cnt);
      end
      checks++;
      if (tail_or(cap, 1, 40) !== 1'b0) begin
         errors++;
         $display("FAIL und_zero got %b want 0", tail_or(cap, 1, 40));
      end
      play_slot(1'b0, 40);
      checks++;
      if (rx_word(cap, 16) !== 32'h0000_9A6B || und1 !== 1'b0) begin
         errors++;
         $display("FAIL und_next got %h und=%b want 00009a6b 0", rx_word(cap, 16), und1);
      end
   endtask

   task automatic test_back_to_back();
      logic l;
      feed_q[0] = 32'h0000_0F0F;
      feed_q[1] = 32'h0000_3C3C;
      feed_q[2] = 32'h0000_8001;
      feed_q[3] = 32'h0000_7FFE;
      feed_q[4] = 32'h0000_5555;
      feed_start(5);
      feed_tick();
      for (int i = 0; i < 5; i++) begin
         l = (i % 2 == 0);
         play_slot(l, 40);
         checks++;
         if (rx_word(cap, 16) !== feed_q[i]) begin
            errors++;
            $display("FAIL b2b_word_%0d got %h want %h", i, rx_word(cap, 16), feed_q[i]);
         end
         if (i < 4) begin
            checks++;
            if (acc_cnt !== 1 || ready_cnt > 1) begin
               errors++;
               $display("FAIL b2b_rate_%0d got acc=%0d rdy=%0d want 1 <=1",
                        i, acc_cnt, ready_cnt);
            end
         end
      end
      checks++;
      if (feed_idx !== 5 || dac_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_total got %0d want 5", feed_idx);
      end
      play_slot(1'b0, 40);
      checks++;
      if (und1 !== 1'b1) begin
         errors++;
         $display("FAIL b2b_drain got und=%b want 1", und1);
      end
   endtask

   task automatic test_reset_mid();
      int bad;
      play_slot(1'b1, 40);
      push_idle(32'h0000_FFFF);
      feed_q[0] = 32'h0000_ABCD;
      feed_start(1);
      play_slot(1'b0, 8);
      checks++;
      if (aud_dacdat !== 1'b1 || dac_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_pre got dat=%b rdy=%b want 1 0", aud_dacdat, dac_ready);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (aud_dacdat !== 1'b0 || dac_ready !== 1'b1 || tx_chan !== 1'b0) begin
         errors++;
         $display("FAIL mid_rst got dat=%b rdy=%b chan=%b want 0 1 0",
                  aud_dacdat, dac_ready, tx_chan);
      end
      repeat (3) tick();
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (aud_dacdat !== 1'b0 || underrun !== 1'b0 || dac_ready !== 1'b1) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL mid_idle got %0d bad cycles want 0", bad);
      end
      play_slot(1'b1, 40);
      checks++;
      if (und1 !== 1'b1 || tail_or(cap, 1, 40) !== 1'b0) begin
         errors++;
         $display("FAIL mid_resume got und=%b or=%b want 1 0", und1, tail_or(cap, 1, 40));
      end
   endtask

   task automatic test_wl24();
      d24_data  = 32'hABC0_FFEE;
      d24_valid = 1'b1;
      for (int i = 0; i < 100 && !d24_ready; i++) tick();
      tick();
      d24_valid = 1'b0;
      play_slot(1'b0, 40);
      checks++;
      if (rx_word(cap24, 24) !== 32'h00C0_FFEE || und24_1 !== 1'b0) begin
         errors++;
         $display("FAIL wl24_word got %h und=%b want 00c0ffee 0",
                  rx_word(cap24, 24), und24_1);
      end
      checks++;
      if (tail_or(cap24, 26, 40) !== 1'b0) begin
         errors++;
         $display("FAIL wl24_tail got %b want 0", tail_or(cap24, 26, 40));
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_pre_edge();
      test_basic();
      test_loopback();
      test_underrun();
      test_back_to_back();
      test_reset_mid();
      test_wl24();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
